// File: rtl/imem_responder_if.sv
// Fetch-side memory bus between the instruction fetch unit (master)
// and the instruction memory responder (slave).
interface imem_responder_if;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wen;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_rvld;
   logic        mem_err;

   modport master (
      output mem_en, mem_addr, mem_wen, mem_wdata,
      input  mem_rdata, mem_rvld, mem_err
   );

   modport slave (
      input  mem_en, mem_addr, mem_wen, mem_wdata,
      output mem_rdata, mem_rvld, mem_err
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-organised SRAM with byte-enabled
// writes, one request per cycle, fixed-latency read pipeline. Misaligned
// or out-of-range accesses are flagged and answered with a NOP.
module imem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic             CLK,
   input  logic             RST,
   imem_responder_if.slave  mem
);
   localparam int          AW    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

   // Request decode
   logic [31:0] offset_d;
   logic        err_d;
   logic        is_read_d;
   logic        wr_en_d;
   logic [AW-1:0] idx_d;
   logic [3:0]  lane_we_d;

   assign offset_d  = mem.mem_addr - BASE_ADDR;   // wraps modulo 2^32
   assign err_d     = (offset_d[1:0] != 2'b00) || (offset_d >= LIMIT);
   assign idx_d     = offset_d[AW+1:2];
   assign is_read_d = (mem.mem_wen == 4'b0000);
   // A write on the reset edge is dropped along with everything in flight.
   assign wr_en_d   = mem.mem_en && !is_read_d && !err_d && !RST;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane_we
         assign lane_we_d[gi] = wr_en_d & mem.mem_wen[gi];
      end
   endgenerate

   // Storage and pipeline state
   logic [31:0]        ram_q [DEPTH_WORDS];
   logic [31:0]        data_q [LATENCY];
   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] rd_q;
   logic [LATENCY-1:0] err_q;
   logic [31:0]        hold_q;

   logic        rvld_d;
   logic [31:0] rdata_d;

   // Array write/read at the accept edge, then delay the read word; no reset
   // so the array maps onto block RAM and keeps its contents across RST.
   always_ff @(posedge CLK) begin
      for (int b = 0; b < 4; b++) begin
         if (lane_we_d[b]) begin
            ram_q[idx_d][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
         end
      end
      data_q[0] <= ram_q[idx_d];
      for (int k = 1; k < LATENCY; k++) begin
         data_q[k] <= data_q[k-1];
      end
   end

   // Control pipeline {valid, is_read, err} and the held read-data register
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q  <= '0;
         rd_q   <= '0;
         err_q  <= '0;
         hold_q <= NOP_WORD;
      end else begin
         vld_q[0] <= mem.mem_en;
         rd_q[0]  <= is_read_d;
         err_q[0] <= err_d;
         for (int k = 1; k < LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            rd_q[k]  <= rd_q[k-1];
            err_q[k] <= err_q[k-1];
         end
         if (rvld_d) begin
            hold_q <= rdata_d;
         end
      end
   end

   // Pipeline exit: responses only for reads; error pulses for any access.
   assign rvld_d        = vld_q[LATENCY-1] & rd_q[LATENCY-1];
   assign rdata_d       = err_q[LATENCY-1] ? NOP_WORD : data_q[LATENCY-1];
   assign mem.mem_rvld  = rvld_d;
   assign mem.mem_err   = vld_q[LATENCY-1] & err_q[LATENCY-1];
   // Read data shows the response in its pulse cycle and holds it afterwards.
   assign mem.mem_rdata = rvld_d ? rdata_d : hold_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder: three instances cover
// LATENCY 1/3/4 and a nonzero base address.
module tb_imem_responder;
   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   imem_responder_if b1 ();
   imem_responder_if b3 ();
   imem_responder_if b4 ();

   imem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000),
                    .NOP_WORD(32'h0000_0013))
      dut1 (.CLK(CLK), .RST(RST), .mem(b1));
   imem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0000_0000),
                    .NOP_WORD(32'h0000_0013))
      dut3 (.CLK(CLK), .RST(RST), .mem(b3));
   imem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .BASE_ADDR(32'h8000_0000),
                    .NOP_WORD(32'h0000_0013))
      dut4 (.CLK(CLK), .RST(RST), .mem(b4));

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_bus(input int d, input logic en, input logic [31:0] a,
                          input logic [3:0] w, input logic [31:0] wd);
      case (d)
         1: begin b1.mem_en = en; b1.mem_addr = a; b1.mem_wen = w; b1.mem_wdata = wd; end
         3: begin b3.mem_en = en; b3.mem_addr = a; b3.mem_wen = w; b3.mem_wdata = wd; end
         default: begin b4.mem_en = en; b4.mem_addr = a; b4.mem_wen = w; b4.mem_wdata = wd; end
      endcase
   endtask

   // One request accepted on the next edge, then the bus goes idle.
   task automatic req(input int d, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] wd);
      set_bus(d, 1'b1, a, w, wd);
      $display("[%0t] dut%0d %s addr=%h wen=%b wdata=%h rst=%b", $time, d,
               (w == 4'b0000) ? "RD" : "WR", a, w, wd, RST);
      step();
      set_bus(d, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   initial begin
      RST = 1'b1;
      set_bus(1, 1'b0, 32'h0, 4'h0, 32'h0);
      set_bus(3, 1'b0, 32'h0, 4'h0, 32'h0);
      set_bus(4, 1'b0, 32'h0, 4'h0, 32'h0);
      step();
      step();
      RST = 1'b0;

      // Reset state
      chk("rst_rvld", {31'b0, b1.mem_rvld}, 32'd0);
      chk("rst_err", {31'b0, b1.mem_err}, 32'd0);
      chk("rst_rdata", b1.mem_rdata, NOP);
      chk("rst_rdata4", b4.mem_rdata, NOP);

      // 1: preload word 0, read it back with LATENCY=1, then hold
      req(1, 32'h0, 4'hF, 32'h0010_0093);
      chk("t1_wr_rvld", {31'b0, b1.mem_rvld}, 32'd0);
      req(1, 32'h0, 4'h0, 32'h0);
      chk("t1_rvld", {31'b0, b1.mem_rvld}, 32'd1);
      chk("t1_rdata", b1.mem_rdata, 32'h0010_0093);
      chk("t1_err", {31'b0, b1.mem_err}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t1_idle_rvld", {31'b0, b1.mem_rvld}, 32'd0);
         chk("t1_hold", b1.mem_rdata, 32'h0010_0093);
      end

      // 3: byte-lane write, read on the next cycle
      req(1, 32'h4, 4'hF, 32'h1122_3344);
      req(1, 32'h4, 4'b0101, 32'hAABB_CCDD);
      req(1, 32'h4, 4'h0, 32'h0);
      chk("t3_rvld", {31'b0, b1.mem_rvld}, 32'd1);
      chk("t3_rdata", b1.mem_rdata, 32'h11BB_33DD);

      // 4: error cases
      req(1, 32'h2, 4'h0, 32'h0);
      chk("t4_mis_rvld", {31'b0, b1.mem_rvld}, 32'd1);
      chk("t4_mis_err", {31'b0, b1.mem_err}, 32'd1);
      chk("t4_mis_rdata", b1.mem_rdata, NOP);
      req(1, 32'h0000_0FFC, 4'hF, 32'hCAFE_0FFC);
      chk("t4_last_wr_err", {31'b0, b1.mem_err}, 32'd0);
      req(1, 32'h0000_0FFC, 4'h0, 32'h0);
      chk("t4_last_rdata", b1.mem_rdata, 32'hCAFE_0FFC);
      chk("t4_last_err", {31'b0, b1.mem_err}, 32'd0);
      req(1, 32'h0000_1000, 4'h0, 32'h0);
      chk("t4_oor_rvld", {31'b0, b1.mem_rvld}, 32'd1);
      chk("t4_oor_err", {31'b0, b1.mem_err}, 32'd1);
      chk("t4_oor_rdata", b1.mem_rdata, NOP);
      req(1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
      chk("t4_wr_err", {31'b0, b1.mem_err}, 32'd1);
      chk("t4_wr_rvld", {31'b0, b1.mem_rvld}, 32'd0);
      chk("t4_wr_hold", b1.mem_rdata, NOP);
      step();
      chk("t4_err_pulse", {31'b0, b1.mem_err}, 32'd0);
      // Out-of-range offset aliases word 0 in the index bits: must be intact
      req(1, 32'h0, 4'h0, 32'h0);
      chk("t4_w0_intact", b1.mem_rdata, 32'h0010_0093);

      // 2: burst reads with LATENCY=3
      for (int i = 0; i < 4; i++) begin
         req(3, 32'(i * 4), 4'hF, 32'(32'hA0 + i));
      end
      for (int i = 0; i < 4; i++) begin
         req(3, 32'(i * 4), 4'h0, 32'h0);
         if (i < 2) begin
            chk("t2_pre_rvld", {31'b0, b3.mem_rvld}, 32'd0);
         end else begin
            chk("t2_rvld", {31'b0, b3.mem_rvld}, 32'd1);
            chk("t2_rdata", b3.mem_rdata, 32'(32'hA0 + i - 2));
         end
      end
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t2_rvld", {31'b0, b3.mem_rvld}, 32'd1);
         chk("t2_rdata", b3.mem_rdata, 32'(32'hA2 + i));
      end
      step();
      chk("t2_end_rvld", {31'b0, b3.mem_rvld}, 32'd0);
      chk("t2_end_hold", b3.mem_rdata, 32'h0000_00A3);

      // 6: nonzero base, valid read of word 1 with LATENCY=4
      req(4, 32'h8000_0004, 4'hF, 32'h5555_AAAA);
      req(4, 32'h8000_0008, 4'hF, 32'h0BAD_F00D);
      req(4, 32'h8000_0004, 4'h0, 32'h0);
      step();
      step();
      chk("t6_pre_rvld", {31'b0, b4.mem_rvld}, 32'd0);
      step();
      chk("t6_rvld", {31'b0, b4.mem_rvld}, 32'd1);
      chk("t6_rdata", b4.mem_rdata, 32'h5555_AAAA);
      chk("t6_err", {31'b0, b4.mem_err}, 32'd0);

      // 5: reset mid-flight, with a write presented on the reset edge
      req(4, 32'h8000_0004, 4'h0, 32'h0);
      req(4, 32'h8000_0004, 4'h0, 32'h0);
      step();
      chk("t5_pre_rvld", {31'b0, b4.mem_rvld}, 32'd0);
      chk("t5_pre_hold", b4.mem_rdata, 32'h5555_AAAA);
      RST = 1'b1;
      req(4, 32'h8000_0008, 4'hF, 32'h1234_5678);
      RST = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("t5_rvld", {31'b0, b4.mem_rvld}, 32'd0);
         chk("t5_err", {31'b0, b4.mem_err}, 32'd0);
         chk("t5_rdata", b4.mem_rdata, NOP);
         step();
      end
      req(4, 32'h8000_0008, 4'h0, 32'h0);
      step();
      step();
      step();
      chk("t5_noreset_wr", b4.mem_rdata, 32'h0BAD_F00D);

      // 6: address below base wraps to an error
      req(4, 32'h7FFF_FFFC, 4'h0, 32'h0);
      step();
      step();
      step();
      chk("t6_low_rvld", {31'b0, b4.mem_rvld}, 32'd1);
      chk("t6_low_err", {31'b0, b4.mem_err}, 32'd1);
      chk("t6_low_rdata", b4.mem_rdata, NOP);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the slave end of the fetch-side memory interface driven by the instruction fetch unit (`mem_en`/`mem_addr`/`mem_wen`/`mem_wdata` in, `mem_rdata`/`mem_rvld` out). It holds a word-organised SRAM model, accepts one request per cycle with no back-pressure, and returns read data through a fixed-latency pipeline. Byte-enabled writes support program loading. Out-of-range or misaligned accesses are flagged, and a NOP is returned in their place.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `LATENCY`, 1: read latency in cycles, legal range 1–4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; word-aligned.
- `NOP_WORD`, 32'h0000_0013: value returned on error (`addi x0,x0,0`).

Ports:
- `CLK` in 1: the single clock. All logic is clocked on the rising edge.
- `RST` in 1: synchronous reset, active-high.
- `mem_en` in 1: request strobe. A request is accepted on every cycle it is high.
- `mem_addr` in 32: byte address.
- `mem_wen` in 4: byte write enables. 0 means read; any nonzero value means write.
- `mem_wdata` in 32: write data, with byte lane i = bits [8i+7:8i].
- `mem_rdata` out 32: read data. It holds its value between responses.
- `mem_rvld` out 1: one-cycle pulse marking a read response.
- `mem_err` out 1: one-cycle pulse marking an erroneous access, for both reads and writes.

## Operation
- **Always ready.** There is no stall input. Each cycle with `mem_en`=1 enters a `LATENCY`-deep pipeline carrying {valid, is_read, err, word index, data}.
- **Address decode:**
  - offset = `mem_addr` − `BASE_ADDR`, computed modulo 2^32.
  - err = (offset[1:0] ≠ 0) | (offset ≥ `DEPTH_WORDS`×4).
  - word index = offset[log2(DEPTH_WORDS)+1:2].
- **Read** (`mem_wen`=0):
  - The array is sampled at the accept edge.
  - The result is delayed `LATENCY`−1 further stages.
  - On exit: `mem_rvld`=1 and `mem_rdata` = data, or `NOP_WORD` if err. `mem_err` = err.
- **Write** (`mem_wen`≠0, err=0):
  - Bytes with `mem_wen`[i]=1 are written at the accept edge.
  - No `mem_rvld` is ever generated for a write.
- **Write with err:**
  - The array is unchanged.
  - `mem_err` pulses `LATENCY` cycles after accept, with `mem_rvld`=0.
- **`mem_rdata` hold:** `mem_rdata` updates only when `mem_rvld` is asserted. Otherwise it keeps its last value, so the fetch unit can re-present a held instruction during a freeze.
- **Ordering:** responses leave in request order. A read issued the cycle after a write to the same word returns the new bytes.
- **Array contents:** never cleared by `RST`. Contents are undefined until written.

## Timing
- **Reset values:** `mem_rvld`=0, `mem_err`=0, `mem_rdata`=`NOP_WORD`, all pipeline valid bits = 0.
- **Reset mid-operation:** all in-flight requests are discarded, with no response or error pulse after `RST` deasserts. A write accepted on the same edge that `RST` is sampled high is not performed.
- **Read latency:**
  - A request accepted at edge t produces `mem_rvld`=1 in the cycle following edge t+`LATENCY`−1.
  - With `LATENCY`=1: request in cycle c, response in cycle c+1.
- **Throughput:** back-to-back reads give back-to-back `mem_rvld` pulses, one per cycle, with no bubbles.
- **Mixed traffic:** interleaved reads and writes keep fixed latency per request. Write slots appear as `mem_rvld`=0 cycles.
- **Address boundaries:**
  - offset = `DEPTH_WORDS`×4−4 is the last valid word.
  - offset = `DEPTH_WORDS`×4 is an error.
  - An address below `BASE_ADDR` wraps to a large offset and is an error.
- **Idle:** `mem_en`=0 inserts an empty slot. `mem_wen`/`mem_wdata`/`mem_addr` are ignored that cycle.

## Test plan
1. **Reset, then read.** Preload word 0 = 32'h0010_0093 via a write with `mem_wen`=4'hF. Read 0x0 with `LATENCY`=1. Expect `mem_rvld` one cycle later, `mem_rdata`=32'h0010_0093, `mem_err`=0, and `mem_rdata` still 32'h0010_0093 for 5 idle cycles afterwards.
2. **Burst reads.**
   - Write words 0–3 = 0xA0..0xA3.
   - With `LATENCY`=3, issue 4 consecutive reads 0x0,0x4,0x8,0xC.
   - Expect `rvld` on the 4 consecutive cycles starting 3 cycles after the first request, with data in order 0xA0..0xA3.
3. **Byte write.**
   - Word 1 = 0x1122_3344.
   - Write 0xAABB_CCDD with `mem_wen`=4'b0101.
   - Read on the next cycle and expect 0x11BB_33DD.
4. **Errors.**
   - Read of 0x2 (misaligned): expect `rvld`=1, `err`=1, `rdata`=0x0000_0013.
   - Read of `DEPTH_WORDS`×4: same response.
   - Write of `DEPTH_WORDS`×4: expect `err`=1, `rvld`=0, and no change to the array.
5. **Reset mid-flight.** With `LATENCY`=4, issue 2 reads, then assert `RST` for 1 cycle two cycles later. Expect no `rvld`/`err` pulse afterwards and `mem_rdata`=0x0000_0013.
6. **Nonzero base.** With `BASE_ADDR`=0x8000_0000: a read at 0x8000_0004 returns word 1, and a read at 0x7FFF_FFFC flags `err`.
